dma_chunk_scheduler: RTL
========================

Name: dma_chunk_scheduler

Overview:
- Sequences the loopback DMA engine for transfers larger than one DMA job.
- Takes a software request (start read/write cache-line addresses, total size in cache lines, go) from the memory map.
- Splits the request into chunks of at most CHUNK_SIZE cache lines, issues each chunk as one DMA rd/wr job, and waits for the DMA write-done before issuing the next.
- Sits between memory_map and the DMA interface; replaces the direct go/size/addr wiring.

Parameters:
- ADDR_WIDTH, 42, cache-line address width (matches t_ccip_clAddr).
- SIZE_WIDTH, 43, width of all size/count fields (ADDR_WIDTH+1).
- CHUNK_SIZE, 512, max cache lines per DMA job; must be >= 1 and < 2**SIZE_WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- go  in  1  software start pulse (level tolerated; acted on only in IDLE/COMPLETE)
- rd_addr  in  ADDR_WIDTH  starting read cache-line address
- wr_addr  in  ADDR_WIDTH  starting write cache-line address
- size  in  SIZE_WIDTH  total cache lines to transfer
- done  out  1  transfer complete; level held until next accepted go
- busy  out  1  high from accepted go until done rises
- dma_rd_addr  out  ADDR_WIDTH  chunk read address
- dma_wr_addr  out  ADDR_WIDTH  chunk write address
- dma_rd_size  out  SIZE_WIDTH  chunk size
- dma_wr_size  out  SIZE_WIDTH  chunk size (always equals dma_rd_size)
- dma_rd_go  out  1  one-cycle chunk start, read channel
- dma_wr_go  out  1  one-cycle chunk start, write channel (same cycle as dma_rd_go)
- dma_wr_done  in  1  DMA write-done level for the current job

Behaviour:
- Reset values: all outputs 0, state IDLE.
  - Reset mid-transfer abandons the request. No further go pulses are issued; the DMA job already in flight is not cancelled.
- States:
  - IDLE, COMPLETE: go accepted → latch rd_addr/wr_addr/size into cur_rd, cur_wr, remaining; clear done; set busy; next ISSUE.
    - If latched size==0, go instead to COMPLETE next cycle, with no DMA go pulses.
  - ISSUE: chunk = min(remaining, CHUNK_SIZE); drive dma_*_addr=cur_*, dma_*_size=chunk; pulse dma_rd_go and dma_wr_go for exactly one cycle; next SETTLE.
  - SETTLE: one cycle ignoring dma_wr_done, which may still show the stale done of the previous job; next WAIT.
  - WAIT: on dma_wr_done=1:
    - cur_rd += chunk, cur_wr += chunk, remaining -= chunk.
    - If remaining becomes 0 → COMPLETE (done=1, busy=0), else → ISSUE.
- Latency:
  - go sampled at cycle N → dma_*_go high at N+1.
  - Final dma_wr_done sampled at cycle M → done high at M+1.
  - Gap between successive chunk go pulses is at least 3 cycles.
- dma_*_addr/size are registered and held stable from the ISSUE cycle until the next ISSUE. They read 0 after reset.
- go is ignored in ISSUE/SETTLE/WAIT; no queuing.
- Address arithmetic wraps modulo 2**ADDR_WIDTH; no error flag.
- Size arithmetic is SIZE_WIDTH unsigned; remaining never underflows, because chunk <= remaining.
- size not a multiple of CHUNK_SIZE: the last chunk carries the remainder.

Optional Feature:
- Macro: DMA_CHUNK_SCHED_PERF_EN.
- Defined:
  - Adds output cycle_count (32 bits) and output chunk_count (SIZE_WIDTH).
  - Both are cleared on accepted go and on reset.
  - cycle_count increments every cycle while busy, saturating at all-ones.
  - chunk_count increments on each dma_rd_go pulse.
  - Both hold their values after done.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package dma_sched_pkg:
  - state enum (IDLE, ISSUE, SETTLE, WAIT, COMPLETE)
  - CL_BYTE_INDEX_BITS=6
  - default CHUNK_SIZE constant
- One sub-module, dma_sched_perf_counters, holds the optional counters and is instantiated only under the macro.
- The scheduler FSM and address/size registers stay in the top module.

Test Plan:
- size=0, go → no dma_rd_go/dma_wr_go ever; done=1 two cycles after go; busy high one cycle.
- size=100, CHUNK_SIZE=512, rd_addr=0x1000, wr_addr=0x2000 → one go pulse with size 100 and addrs 0x1000/0x2000; done one cycle after dma_wr_done.
- size=1300, CHUNK_SIZE=512 → three jobs:
  - sizes 512/512/276
  - rd addrs 0x1000/0x1200/0x1400
  - done only after the third dma_wr_done
- Stale done: dma_wr_done held 1 from the previous job through the next ISSUE → scheduler waits past SETTLE and does not advance until dma_wr_done drops then rises.
- go pulsed in WAIT → ignored, chunk sequence unchanged; rst asserted in WAIT → all outputs 0 next cycle, no further go pulses.
- rd_addr=2**ADDR_WIDTH-256, size=512, CHUNK_SIZE=256 → second chunk dma_rd_addr=0 (wrap). With DMA_CHUNK_SCHED_PERF_EN defined, chunk_count=2.

Source files
------------

// File: rtl/dma_sched_pkg.sv
// dma_sched_pkg
//   Shared types and constants for the DMA chunk scheduler.
//   - sched_state_t      : scheduler FSM states
//   - CL_BYTE_INDEX_BITS : byte-offset bits inside one cache line (64 B lines)
//   - DEFAULT_CHUNK_SIZE : default maximum cache lines per DMA job
package dma_sched_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    SETTLE   = 3'd2,
    WAIT     = 3'd3,
    COMPLETE = 3'd4
  } sched_state_t;

  localparam int CL_BYTE_INDEX_BITS = 6;
  localparam int DEFAULT_CHUNK_SIZE = 512;

endpackage

// File: rtl/dma_sched_perf_counters.sv
// dma_sched_perf_counters
//   Optional transfer statistics for dma_chunk_scheduler (only built when
//   DMA_CHUNK_SCHED_PERF_EN is defined).
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   clear        : accepted go; restarts both counters
//   busy         : scheduler busy level; counted every cycle it is high
//   chunk_go     : one-cycle chunk start pulse
//   cycle_count  : busy cycles of the last/current transfer, saturating
//   chunk_count  : chunks issued for the last/current transfer
module dma_sched_perf_counters #(
  parameter int SIZE_WIDTH = 43
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  busy,
  input  logic                  chunk_go,
  output logic [31:0]           cycle_count,
  output logic [SIZE_WIDTH-1:0] chunk_count
);

  localparam logic [SIZE_WIDTH-1:0] ONE = {{(SIZE_WIDTH-1){1'b0}}, 1'b1};

  // Busy-cycle and chunk counters; both hold after done until the next go.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cycle_count <= 32'd0;
      chunk_count <= {SIZE_WIDTH{1'b0}};
    end else begin
      if (busy && (cycle_count != 32'hFFFF_FFFF)) begin
        cycle_count <= cycle_count + 32'd1;
      end
      if (chunk_go) begin
        chunk_count <= chunk_count + ONE;
      end
    end
  end

endmodule

// File: rtl/dma_chunk_scheduler.sv
// dma_chunk_scheduler
//   Splits one software transfer request into DMA jobs of at most CHUNK_SIZE
//   cache lines and issues them one at a time, waiting for the DMA write-done
//   of each job before issuing the next.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   go, rd_addr, wr_addr, size: software request (acted on in IDLE/COMPLETE)
//   done, busy                : transfer status levels
//   dma_rd_addr/dma_wr_addr   : current chunk addresses (registered)
//   dma_rd_size/dma_wr_size   : current chunk size (registered, identical)
//   dma_rd_go/dma_wr_go       : one-cycle chunk start pulses
//   dma_wr_done               : DMA write-done level for the current job
//   cycle_count, chunk_count  : present only with DMA_CHUNK_SCHED_PERF_EN
module dma_chunk_scheduler
  import dma_sched_pkg::*;
#(
  parameter int ADDR_WIDTH = 42,
  parameter int SIZE_WIDTH = 43,
  parameter int CHUNK_SIZE = DEFAULT_CHUNK_SIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [SIZE_WIDTH-1:0] size,
  output logic                  done,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] dma_rd_addr,
  output logic [ADDR_WIDTH-1:0] dma_wr_addr,
  output logic [SIZE_WIDTH-1:0] dma_rd_size,
  output logic [SIZE_WIDTH-1:0] dma_wr_size,
  output logic                  dma_rd_go,
  output logic                  dma_wr_go,
  input  logic                  dma_wr_done
`ifdef DMA_CHUNK_SCHED_PERF_EN
  ,
  output logic [31:0]           cycle_count,
  output logic [SIZE_WIDTH-1:0] chunk_count
`endif
);

  localparam logic [SIZE_WIDTH-1:0] CHUNK = SIZE_WIDTH'(CHUNK_SIZE);
  localparam logic [SIZE_WIDTH-1:0] ZERO  = {SIZE_WIDTH{1'b0}};

  function automatic logic [SIZE_WIDTH-1:0] clip_chunk(input logic [SIZE_WIDTH-1:0] n);
    return (n < CHUNK) ? n : CHUNK;
  endfunction

  sched_state_t          state_r;
  logic [SIZE_WIDTH-1:0] remaining_r;
  logic                  go_accept_s;
  logic [SIZE_WIDTH-1:0] rem_next_s;
  logic [ADDR_WIDTH-1:0] rd_next_s;
  logic [ADDR_WIDTH-1:0] wr_next_s;

  // Next-chunk arithmetic. The dma_*_addr/size registers double as the
  // current-chunk pointers; address sums wrap modulo 2**ADDR_WIDTH.
  always_comb begin
    go_accept_s = go && ((state_r == IDLE) || (state_r == COMPLETE));
    rem_next_s  = remaining_r - dma_rd_size;
    rd_next_s   = dma_rd_addr + dma_rd_size[ADDR_WIDTH-1:0];
    wr_next_s   = dma_wr_addr + dma_rd_size[ADDR_WIDTH-1:0];
  end

  // Scheduler FSM. Chunk outputs and go pulses are loaded on the edge that
  // enters ISSUE, so the pulse is visible during the ISSUE cycle itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      remaining_r <= ZERO;
      done        <= 1'b0;
      busy        <= 1'b0;
      dma_rd_addr <= {ADDR_WIDTH{1'b0}};
      dma_wr_addr <= {ADDR_WIDTH{1'b0}};
      dma_rd_size <= ZERO;
      dma_wr_size <= ZERO;
      dma_rd_go   <= 1'b0;
      dma_wr_go   <= 1'b0;
    end else begin
      dma_rd_go <= 1'b0;
      dma_wr_go <= 1'b0;
      case (state_r)
        IDLE, COMPLETE: begin
          if (go_accept_s) begin
            remaining_r <= size;
            done        <= 1'b0;
            busy        <= 1'b1;
            state_r     <= ISSUE;
            // A zero-length request passes through ISSUE without a job.
            if (size != ZERO) begin
              dma_rd_addr <= rd_addr;
              dma_wr_addr <= wr_addr;
              dma_rd_size <= clip_chunk(size);
              dma_wr_size <= clip_chunk(size);
              dma_rd_go   <= 1'b1;
              dma_wr_go   <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (remaining_r == ZERO) begin
            state_r <= COMPLETE;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            state_r <= SETTLE;
          end
        end
        // dma_wr_done may still show the previous job's done here.
        SETTLE: state_r <= WAIT;
        WAIT: begin
          if (dma_wr_done) begin
            remaining_r <= rem_next_s;
            if (rem_next_s == ZERO) begin
              state_r <= COMPLETE;
              done    <= 1'b1;
              busy    <= 1'b0;
            end else begin
              state_r     <= ISSUE;
              dma_rd_addr <= rd_next_s;
              dma_wr_addr <= wr_next_s;
              dma_rd_size <= clip_chunk(rem_next_s);
              dma_wr_size <= clip_chunk(rem_next_s);
              dma_rd_go   <= 1'b1;
              dma_wr_go   <= 1'b1;
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

`ifdef DMA_CHUNK_SCHED_PERF_EN
  dma_sched_perf_counters #(
    .SIZE_WIDTH (SIZE_WIDTH)
  ) u_perf (
    .clk         (clk),
    .rst         (rst),
    .clear       (go_accept_s),
    .busy        (busy),
    .chunk_go    (dma_rd_go),
    .cycle_count (cycle_count),
    .chunk_count (chunk_count)
  );
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
